// File: rtl/task_dispatcher.sv
// -----------------------------------------------------------------------------
// task_dispatcher
// Queues build and parse requests arriving from the register interface and
// hands each one to a free processing unit. Builds go to packet builder pb0
// or pb1, and parses go to the packet parser pp. For each dispatch the block
// loads the unit's config register and pulses the unit's start for one cycle.
// It also tracks the work in flight and reports an overall controller busy.
//
// Ports
//   clk                       clock
//   reset                     asynchronous, active-high reset
//   pb_req_i / pb_cfg_i[94:0] build request valid / build config
//   pb_ack_o                  build request accepted this cycle (combinational)
//   pp_req_i / pp_cfg_i[32:0] parse request valid / parse config
//   pp_ack_o                  parse request accepted this cycle (combinational)
//   pb0/pb1/pp_busy_i         unit busy status
//   pb0/pb1/pp_irq_i          unit done, 1-cycle pulse
//   pb0/pb1/pp_start_o        registered 1-cycle start pulse per unit
//   pb0/pb1_cfg_o[94:0]       config held to each builder until its next dispatch
//   pp_cfg_o[32:0]            config held to the parser until its next dispatch
//   cont_busy_o               registered: a queue is non-empty or a unit is in flight
// -----------------------------------------------------------------------------
module task_dispatcher #(
  parameter int BQ_DEPTH = 2,
  parameter int PQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pb_req_i,
  input  logic [94:0] pb_cfg_i,
  output logic        pb_ack_o,
  input  logic        pp_req_i,
  input  logic [32:0] pp_cfg_i,
  output logic        pp_ack_o,
  input  logic        pb0_busy_i,
  input  logic        pb1_busy_i,
  input  logic        pp_busy_i,
  input  logic        pb0_irq_i,
  input  logic        pb1_irq_i,
  input  logic        pp_irq_i,
  output logic        pb0_start_o,
  output logic        pb1_start_o,
  output logic        pp_start_o,
  output logic [94:0] pb0_cfg_o,
  output logic [94:0] pb1_cfg_o,
  output logic [32:0] pp_cfg_o,
  output logic        cont_busy_o
);

  localparam int BAW = $clog2(BQ_DEPTH);
  localparam int PAW = $clog2(PQ_DEPTH);

  // Round-robin memory: which builder took the most recent build.
  localparam logic RR_PB0 = 1'b0;
  localparam logic RR_PB1 = 1'b1;

  localparam logic [BAW:0] BQ_ONE = (BAW+1)'(1'b1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [94:0]  bq_mem_r [BQ_DEPTH];
  logic [BAW:0] bq_wr_r;
  logic [BAW:0] bq_rd_r;
  logic [32:0]  pq_mem_r [PQ_DEPTH];
  logic [PAW:0] pq_wr_r;
  logic [PAW:0] pq_rd_r;

  logic         rr_r;
  logic         infl_pb0_r;
  logic         infl_pb1_r;
  logic         infl_pp_r;

  logic         pb0_start_r;
  logic         pb1_start_r;
  logic         pp_start_r;
  logic [94:0]  pb0_cfg_r;
  logic [94:0]  pb1_cfg_r;
  logic [32:0]  pp_cfg_r;
  logic         cont_busy_r;

  // ---------------------------------------------------------------------------
  // Queue status and handshake
  // ---------------------------------------------------------------------------
  logic         bq_full_s;
  logic         bq_empty_s;
  logic [BAW:0] bq_cnt_s;
  logic         bq_push_s;
  logic         pq_full_s;
  logic         pq_empty_s;
  logic         pq_push_s;

  assign bq_full_s  = (bq_wr_r[BAW] != bq_rd_r[BAW]) &&
                      (bq_wr_r[BAW-1:0] == bq_rd_r[BAW-1:0]);
  assign bq_empty_s = (bq_wr_r == bq_rd_r);
  assign bq_cnt_s   = bq_wr_r - bq_rd_r;
  assign pq_full_s  = (pq_wr_r[PAW] != pq_rd_r[PAW]) &&
                      (pq_wr_r[PAW-1:0] == pq_rd_r[PAW-1:0]);
  assign pq_empty_s = (pq_wr_r == pq_rd_r);

  // Fullness comes from registered pointers only, so a pop in the same cycle
  // never opens a slot for the request that arrives in that cycle.
  assign bq_push_s = pb_req_i & ~bq_full_s;
  assign pq_push_s = pp_req_i & ~pq_full_s;
  assign pb_ack_o  = bq_push_s;
  assign pp_ack_o  = pq_push_s;

  // ---------------------------------------------------------------------------
  // Dispatch candidates. The request that is accepted this cycle is visible
  // to the dispatcher straight away, which lets its start pulse appear in the
  // cycle after acceptance.
  // ---------------------------------------------------------------------------
  logic [BAW-1:0] bq_rd1_idx_s;
  logic [94:0]    bq_e0_s;
  logic [94:0]    bq_e1_s;
  logic           bq_avail0_s;
  logic           bq_avail1_s;
  logic [32:0]    pq_e0_s;
  logic           pq_avail0_s;

  assign bq_rd1_idx_s = bq_rd_r[BAW-1:0] + BAW'(1'b1);
  assign bq_e0_s      = bq_empty_s ? pb_cfg_i : bq_mem_r[bq_rd_r[BAW-1:0]];
  assign bq_e1_s      = (bq_cnt_s > BQ_ONE) ? bq_mem_r[bq_rd1_idx_s] : pb_cfg_i;
  assign bq_avail0_s  = ~bq_empty_s | bq_push_s;
  assign bq_avail1_s  = (bq_cnt_s > BQ_ONE) | ((bq_cnt_s == BQ_ONE) & bq_push_s);
  assign pq_e0_s      = pq_empty_s ? pp_cfg_i : pq_mem_r[pq_rd_r[PAW-1:0]];
  assign pq_avail0_s  = ~pq_empty_s | pq_push_s;

  // A unit is free only when no dispatch is outstanding and the unit itself
  // is idle. The in-flight flag clears one edge after irq, so a unit is free
  // at the earliest in the cycle after its irq.
  logic pb0_free_s;
  logic pb1_free_s;
  logic pp_free_s;

  assign pb0_free_s = ~infl_pb0_r & ~pb0_busy_i;
  assign pb1_free_s = ~infl_pb1_r & ~pb1_busy_i;
  assign pp_free_s  = ~infl_pp_r  & ~pp_busy_i;

  logic        pb0_go_s;
  logic        pb1_go_s;
  logic [94:0] pb0_cfg_nxt_s;
  logic [94:0] pb1_cfg_nxt_s;
  logic [1:0]  bq_pop_s;
  logic        rr_nxt_s;
  logic        pp_go_s;

  // Builder selection: the head goes to the single free builder. When both
  // are free the head goes to the builder that was not used last, and a
  // second entry, if present, goes to the other builder in the same cycle.
  always_comb begin
    pb0_go_s      = 1'b0;
    pb1_go_s      = 1'b0;
    pb0_cfg_nxt_s = bq_e0_s;
    pb1_cfg_nxt_s = bq_e0_s;
    bq_pop_s      = 2'd0;
    rr_nxt_s      = rr_r;
    if (bq_avail0_s) begin
      if (pb0_free_s && pb1_free_s) begin
        if (rr_r == RR_PB1) begin
          pb0_go_s      = 1'b1;
          pb0_cfg_nxt_s = bq_e0_s;
          if (bq_avail1_s) begin
            pb1_go_s      = 1'b1;
            pb1_cfg_nxt_s = bq_e1_s;
            bq_pop_s      = 2'd2;
            rr_nxt_s      = RR_PB1;
          end else begin
            bq_pop_s = 2'd1;
            rr_nxt_s = RR_PB0;
          end
        end else begin
          pb1_go_s      = 1'b1;
          pb1_cfg_nxt_s = bq_e0_s;
          if (bq_avail1_s) begin
            pb0_go_s      = 1'b1;
            pb0_cfg_nxt_s = bq_e1_s;
            bq_pop_s      = 2'd2;
            rr_nxt_s      = RR_PB0;
          end else begin
            bq_pop_s = 2'd1;
            rr_nxt_s = RR_PB1;
          end
        end
      end else if (pb0_free_s) begin
        pb0_go_s      = 1'b1;
        pb0_cfg_nxt_s = bq_e0_s;
        bq_pop_s      = 2'd1;
        rr_nxt_s      = RR_PB0;
      end else if (pb1_free_s) begin
        pb1_go_s      = 1'b1;
        pb1_cfg_nxt_s = bq_e0_s;
        bq_pop_s      = 2'd1;
        rr_nxt_s      = RR_PB1;
      end else begin
        bq_pop_s = 2'd0;
      end
    end else begin
      bq_pop_s = 2'd0;
    end
  end

  assign pp_go_s = pq_avail0_s & pp_free_s;

  // ---------------------------------------------------------------------------
  // Next-state values for pointers and in-flight flags
  // ---------------------------------------------------------------------------
  logic [BAW:0] bq_wr_nxt_s;
  logic [BAW:0] bq_rd_nxt_s;
  logic [PAW:0] pq_wr_nxt_s;
  logic [PAW:0] pq_rd_nxt_s;
  logic         infl_pb0_nxt_s;
  logic         infl_pb1_nxt_s;
  logic         infl_pp_nxt_s;
  logic         cont_busy_nxt_s;

  assign bq_wr_nxt_s = bq_wr_r + (BAW+1)'(bq_push_s);
  assign bq_rd_nxt_s = bq_rd_r + (BAW+1)'(bq_pop_s);
  assign pq_wr_nxt_s = pq_wr_r + (PAW+1)'(pq_push_s);
  assign pq_rd_nxt_s = pq_rd_r + (PAW+1)'(pp_go_s);

  // A dispatch takes priority over a coincident irq. An irq that arrives
  // while the flag is already clear leaves the flag clear.
  assign infl_pb0_nxt_s = pb0_go_s ? 1'b1 : (pb0_irq_i ? 1'b0 : infl_pb0_r);
  assign infl_pb1_nxt_s = pb1_go_s ? 1'b1 : (pb1_irq_i ? 1'b0 : infl_pb1_r);
  assign infl_pp_nxt_s  = pp_go_s  ? 1'b1 : (pp_irq_i  ? 1'b0 : infl_pp_r);

  // Built from next-state values so the registered flag matches the
  // registered queue and in-flight state of the same cycle.
  assign cont_busy_nxt_s = (bq_wr_nxt_s != bq_rd_nxt_s) |
                           (pq_wr_nxt_s != pq_rd_nxt_s) |
                           infl_pb0_nxt_s | infl_pb1_nxt_s | infl_pp_nxt_s;

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------

  // Build queue storage: write the accepted request at the write pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BQ_DEPTH; i++) begin
        bq_mem_r[i] <= 95'd0;
      end
    end else if (bq_push_s) begin
      bq_mem_r[bq_wr_r[BAW-1:0]] <= pb_cfg_i;
    end
  end

  // Parse queue storage: write the accepted request at the write pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PQ_DEPTH; i++) begin
        pq_mem_r[i] <= 33'd0;
      end
    end else if (pq_push_s) begin
      pq_mem_r[pq_wr_r[PAW-1:0]] <= pp_cfg_i;
    end
  end

  // Pointers, round-robin memory, in-flight flags and controller busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bq_wr_r     <= {(BAW+1){1'b0}};
      bq_rd_r     <= {(BAW+1){1'b0}};
      pq_wr_r     <= {(PAW+1){1'b0}};
      pq_rd_r     <= {(PAW+1){1'b0}};
      rr_r        <= RR_PB1;
      infl_pb0_r  <= 1'b0;
      infl_pb1_r  <= 1'b0;
      infl_pp_r   <= 1'b0;
      cont_busy_r <= 1'b0;
    end else begin
      bq_wr_r     <= bq_wr_nxt_s;
      bq_rd_r     <= bq_rd_nxt_s;
      pq_wr_r     <= pq_wr_nxt_s;
      pq_rd_r     <= pq_rd_nxt_s;
      rr_r        <= rr_nxt_s;
      infl_pb0_r  <= infl_pb0_nxt_s;
      infl_pb1_r  <= infl_pb1_nxt_s;
      infl_pp_r   <= infl_pp_nxt_s;
      cont_busy_r <= cont_busy_nxt_s;
    end
  end

  // Start pulses and unit configs. A config is loaded only on a dispatch to
  // its unit and is held until the next one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pb0_start_r <= 1'b0;
      pb1_start_r <= 1'b0;
      pp_start_r  <= 1'b0;
      pb0_cfg_r   <= 95'd0;
      pb1_cfg_r   <= 95'd0;
      pp_cfg_r    <= 33'd0;
    end else begin
      pb0_start_r <= pb0_go_s;
      pb1_start_r <= pb1_go_s;
      pp_start_r  <= pp_go_s;
      if (pb0_go_s) begin
        pb0_cfg_r <= pb0_cfg_nxt_s;
      end
      if (pb1_go_s) begin
        pb1_cfg_r <= pb1_cfg_nxt_s;
      end
      if (pp_go_s) begin
        pp_cfg_r <= pq_e0_s;
      end
    end
  end

  assign pb0_start_o = pb0_start_r;
  assign pb1_start_o = pb1_start_r;
  assign pp_start_o  = pp_start_r;
  assign pb0_cfg_o   = pb0_cfg_r;
  assign pb1_cfg_o   = pb1_cfg_r;
  assign pp_cfg_o    = pp_cfg_r;
  assign cont_busy_o = cont_busy_r;

endmodule

// File: tb/tb_task_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_task_dispatcher
// Directed scenarios for task_dispatcher. Each cycle the inputs are driven
// 1 time unit after the rising edge and the outputs are read 1 unit later.
// -----------------------------------------------------------------------------
module tb_task_dispatcher;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pb_req_i = 1'b0;
  logic [94:0] pb_cfg_i = 95'd0;
  logic        pb_ack_o;
  logic        pp_req_i = 1'b0;
  logic [32:0] pp_cfg_i = 33'd0;
  logic        pp_ack_o;
  logic        pb0_busy_i = 1'b0;
  logic        pb1_busy_i = 1'b0;
  logic        pp_busy_i = 1'b0;
  logic        pb0_irq_i = 1'b0;
  logic        pb1_irq_i = 1'b0;
  logic        pp_irq_i = 1'b0;
  logic        pb0_start_o;
  logic        pb1_start_o;
  logic        pp_start_o;
  logic [94:0] pb0_cfg_o;
  logic [94:0] pb1_cfg_o;
  logic [32:0] pp_cfg_o;
  logic        cont_busy_o;

  int checks = 0;
  int failures = 0;

  task_dispatcher #(.BQ_DEPTH(2), .PQ_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .pb_req_i(pb_req_i), .pb_cfg_i(pb_cfg_i), .pb_ack_o(pb_ack_o),
    .pp_req_i(pp_req_i), .pp_cfg_i(pp_cfg_i), .pp_ack_o(pp_ack_o),
    .pb0_busy_i(pb0_busy_i), .pb1_busy_i(pb1_busy_i), .pp_busy_i(pp_busy_i),
    .pb0_irq_i(pb0_irq_i), .pb1_irq_i(pb1_irq_i), .pp_irq_i(pp_irq_i),
    .pb0_start_o(pb0_start_o), .pb1_start_o(pb1_start_o), .pp_start_o(pp_start_o),
    .pb0_cfg_o(pb0_cfg_o), .pb1_cfg_o(pb1_cfg_o), .pp_cfg_o(pp_cfg_o),
    .cont_busy_o(cont_busy_o)
  );

  always #5 clk = ~clk;

  // Build config with the given addr_in and byte_cnt and fixed other fields.
  function automatic logic [94:0] mk_bcfg(input logic [31:0] a, input logic [3:0] n);
    mk_bcfg = {a, n, 4'h3, 1'b1, 1'b0, 1'b0, 1'b1, 4'h6, 8'hA5, 3'h2, 4'h1, ~a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    pb_req_i = 1'b0; pb_cfg_i = 95'd0; pp_req_i = 1'b0; pp_cfg_i = 33'd0;
    pb0_busy_i = 1'b0; pb1_busy_i = 1'b0; pp_busy_i = 1'b0;
    pb0_irq_i = 1'b0; pb1_irq_i = 1'b0; pp_irq_i = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick(); tick(); #1;
    checks++;
    if ({pb0_start_o, pb1_start_o, pp_start_o, pb_ack_o, pp_ack_o, cont_busy_o} !== 6'b0) begin
      failures++;
      $display("FAIL rst_flags got=%b exp=000000",
               {pb0_start_o, pb1_start_o, pp_start_o, pb_ack_o, pp_ack_o, cont_busy_o});
    end
    checks++;
    if ({pb0_cfg_o, pb1_cfg_o, pp_cfg_o} !== 223'd0) begin
      failures++;
      $display("FAIL rst_cfgs got=%h exp=0", {pb0_cfg_o, pb1_cfg_o, pp_cfg_o});
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (cont_busy_o !== 1'b0) begin
      failures++; $display("FAIL rst_release_busy got=%b exp=0", cont_busy_o);
    end
  endtask

  task automatic test_single_build();
    logic [94:0] c;
    c = mk_bcfg(32'd2, 4'd7);
    do_reset();
    pb_req_i = 1'b1; pb_cfg_i = c; #1;
    checks++;
    if (pb_ack_o !== 1'b1) begin failures++; $display("FAIL t1_ack got=%b exp=1", pb_ack_o); end
    tick();
    pb_req_i = 1'b0; #1;
    checks++;
    if ({pb0_start_o, pb1_start_o} !== 2'b10) begin
      failures++; $display("FAIL t1_start got=%b exp=10", {pb0_start_o, pb1_start_o});
    end
    checks++;
    if (pb0_cfg_o !== c) begin failures++; $display("FAIL t1_cfg got=%h exp=%h", pb0_cfg_o, c); end
    checks++;
    if (cont_busy_o !== 1'b1) begin failures++; $display("FAIL t1_busy got=%b exp=1", cont_busy_o); end
    tick();
    pb0_busy_i = 1'b1; #1;
    checks++;
    if (pb0_start_o !== 1'b0) begin failures++; $display("FAIL t1_start_drop got=%b exp=0", pb0_start_o); end
    checks++;
    if (pb0_cfg_o !== c) begin failures++; $display("FAIL t1_cfg_held got=%h exp=%h", pb0_cfg_o, c); end
    tick();
    pb0_irq_i = 1'b1; pb0_busy_i = 1'b0;
    tick();
    pb0_irq_i = 1'b0; #1;
    checks++;
    if (cont_busy_o !== 1'b0) begin failures++; $display("FAIL t1_idle got=%b exp=0", cont_busy_o); end
  endtask

  task automatic test_back_to_back();
    logic [94:0] a, b, c;
    a = mk_bcfg(32'h10, 4'd1); b = mk_bcfg(32'h20, 4'd2); c = mk_bcfg(32'h30, 4'd3);
    do_reset();
    pb_req_i = 1'b1; pb_cfg_i = a; #1;
    checks++;
    if (pb_ack_o !== 1'b1) begin failures++; $display("FAIL t2_ack1 got=%b exp=1", pb_ack_o); end
    tick();
    pb_cfg_i = b; #1;
    checks++;
    if ({pb_ack_o, pb0_start_o, pb1_start_o} !== 3'b110) begin
      failures++; $display("FAIL t2_c1 got=%b exp=110", {pb_ack_o, pb0_start_o, pb1_start_o});
    end
    checks++;
    if (pb0_cfg_o !== a) begin failures++; $display("FAIL t2_cfg_a got=%h exp=%h", pb0_cfg_o, a); end
    tick();
    pb_cfg_i = c; pb0_busy_i = 1'b1; #1;
    checks++;
    if ({pb_ack_o, pb0_start_o, pb1_start_o} !== 3'b101) begin
      failures++; $display("FAIL t2_c2 got=%b exp=101", {pb_ack_o, pb0_start_o, pb1_start_o});
    end
    checks++;
    if (pb1_cfg_o !== b) begin failures++; $display("FAIL t2_cfg_b got=%h exp=%h", pb1_cfg_o, b); end
    tick();
    pb_req_i = 1'b0; pb1_busy_i = 1'b1; #1;
    checks++;
    if ({pb0_start_o, pb1_start_o, cont_busy_o} !== 3'b001) begin
      failures++; $display("FAIL t2_held got=%b exp=001", {pb0_start_o, pb1_start_o, cont_busy_o});
    end
    tick();
    pb0_irq_i = 1'b1; pb0_busy_i = 1'b0; #1;
    checks++;
    if (pb0_start_o !== 1'b0) begin failures++; $display("FAIL t2_irq_cycle got=%b exp=0", pb0_start_o); end
    tick();
    pb0_irq_i = 1'b0; #1;
    checks++;
    if (pb0_start_o !== 1'b0) begin failures++; $display("FAIL t2_irq_plus1 got=%b exp=0", pb0_start_o); end
    tick(); #1;
    checks++;
    if ({pb0_start_o, pb1_start_o} !== 2'b10) begin
      failures++; $display("FAIL t2_third_start got=%b exp=10", {pb0_start_o, pb1_start_o});
    end
    checks++;
    if (pb0_cfg_o !== c) begin failures++; $display("FAIL t2_cfg_c got=%h exp=%h", pb0_cfg_o, c); end
  endtask

  task automatic test_queue_full();
    logic [94:0] d0, d1, d2;
    d0 = mk_bcfg(32'hA0, 4'd4); d1 = mk_bcfg(32'hA1, 4'd5); d2 = mk_bcfg(32'hA2, 4'd6);
    do_reset();
    pb0_busy_i = 1'b1; pb1_busy_i = 1'b1;
    pb_req_i = 1'b1; pb_cfg_i = d0; #1;
    checks++;
    if (pb_ack_o !== 1'b1) begin failures++; $display("FAIL t3_ack0 got=%b exp=1", pb_ack_o); end
    tick();
    pb_cfg_i = d1; #1;
    checks++;
    if (pb_ack_o !== 1'b1) begin failures++; $display("FAIL t3_ack1 got=%b exp=1", pb_ack_o); end
    tick();
    pb_cfg_i = d2; #1;
    checks++;
    if (pb_ack_o !== 1'b0) begin failures++; $display("FAIL t3_full_ack got=%b exp=0", pb_ack_o); end
    tick();
    pb0_busy_i = 1'b0; #1;
    checks++;
    if (pb_ack_o !== 1'b0) begin failures++; $display("FAIL t3_pop_same_cycle got=%b exp=0", pb_ack_o); end
    tick();
    pb0_busy_i = 1'b1; #1;
    checks++;
    if ({pb0_start_o, pb_ack_o} !== 2'b11) begin
      failures++; $display("FAIL t3_after_pop got=%b exp=11", {pb0_start_o, pb_ack_o});
    end
    checks++;
    if (pb0_cfg_o !== d0) begin failures++; $display("FAIL t3_cfg_d0 got=%h exp=%h", pb0_cfg_o, d0); end
    tick();
    pb_req_i = 1'b0; pb1_busy_i = 1'b0; #1;
    checks++;
    if (pb1_start_o !== 1'b0) begin failures++; $display("FAIL t3_pb1_early got=%b exp=0", pb1_start_o); end
    tick();
    pb1_busy_i = 1'b1; #1;
    checks++;
    if (pb1_start_o !== 1'b1) begin failures++; $display("FAIL t3_pb1_start got=%b exp=1", pb1_start_o); end
    checks++;
    if (pb1_cfg_o !== d1) begin failures++; $display("FAIL t3_cfg_d1 got=%h exp=%h", pb1_cfg_o, d1); end
    tick(); #1;
    checks++;
    if ({pb0_start_o, pb1_start_o, cont_busy_o} !== 3'b001) begin
      failures++; $display("FAIL t3_d2_held got=%b exp=001", {pb0_start_o, pb1_start_o, cont_busy_o});
    end
  endtask

  task automatic test_parse_hold();
    logic [32:0] e;
    e = {32'd5, 1'b1};
    do_reset();
    pp_busy_i = 1'b1;
    pp_req_i = 1'b1; pp_cfg_i = e; #1;
    checks++;
    if (pp_ack_o !== 1'b1) begin failures++; $display("FAIL t4_ack got=%b exp=1", pp_ack_o); end
    tick();
    pp_req_i = 1'b0; pp_cfg_i = 33'd0; #1;
    checks++;
    if (pp_start_o !== 1'b0) begin failures++; $display("FAIL t4_held got=%b exp=0", pp_start_o); end
    tick();
    pp_irq_i = 1'b1; #1;
    tick();
    pp_irq_i = 1'b0; pp_busy_i = 1'b0; #1;
    checks++;
    if (pp_start_o !== 1'b0) begin failures++; $display("FAIL t4_irq_ignored got=%b exp=0", pp_start_o); end
    tick(); #1;
    checks++;
    if (pp_start_o !== 1'b1) begin failures++; $display("FAIL t4_start got=%b exp=1", pp_start_o); end
    checks++;
    if (pp_cfg_o !== e) begin failures++; $display("FAIL t4_cfg got=%h exp=%h", pp_cfg_o, e); end
  endtask

  task automatic test_reset_mid();
    logic [94:0] c;
    c = mk_bcfg(32'hBEEF, 4'd9);
    do_reset();
    pb_req_i = 1'b1; pb_cfg_i = c;
    tick();
    pb_req_i = 1'b0; #1;
    checks++;
    if (pb0_start_o !== 1'b1) begin failures++; $display("FAIL t5_start got=%b exp=1", pb0_start_o); end
    reset = 1'b1; #1;
    checks++;
    if ({pb0_start_o, cont_busy_o} !== 2'b00) begin
      failures++; $display("FAIL t5_async_flags got=%b exp=00", {pb0_start_o, cont_busy_o});
    end
    checks++;
    if (pb0_cfg_o !== 95'd0) begin failures++; $display("FAIL t5_async_cfg got=%h exp=0", pb0_cfg_o); end
    tick();
    reset = 1'b0; pb0_irq_i = 1'b1; #1;
    checks++;
    if (cont_busy_o !== 1'b0) begin failures++; $display("FAIL t5_release_busy got=%b exp=0", cont_busy_o); end
    tick();
    pb0_irq_i = 1'b0; #1;
    checks++;
    if ({pb0_start_o, cont_busy_o} !== 2'b00) begin
      failures++; $display("FAIL t5_late_irq got=%b exp=00", {pb0_start_o, cont_busy_o});
    end
  endtask

  task automatic test_round_robin();
    logic [94:0] c;
    logic        exp_pb0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_pb0 = (i % 2 == 0);
      c = mk_bcfg(32'h100 + i, 4'(i));
      pb_req_i = 1'b1; pb_cfg_i = c;
      tick();
      pb_req_i = 1'b0; #1;
      checks++;
      if ({pb0_start_o, pb1_start_o} !== {exp_pb0, ~exp_pb0}) begin
        failures++;
        $display("FAIL t6_order_%0d got=%b exp=%b", i, {pb0_start_o, pb1_start_o}, {exp_pb0, ~exp_pb0});
      end
      checks++;
      if ((exp_pb0 ? pb0_cfg_o : pb1_cfg_o) !== c) begin
        failures++;
        $display("FAIL t6_cfg_%0d got=%h exp=%h", i, (exp_pb0 ? pb0_cfg_o : pb1_cfg_o), c);
      end
      tick();
      pb0_irq_i = exp_pb0;
      pb1_irq_i = ~exp_pb0 | (i == 0);
      tick();
      pb0_irq_i = 1'b0; pb1_irq_i = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_single_build();
    test_back_to_back();
    test_queue_full();
    test_parse_hold();
    test_reset_mid();
    test_round_robin();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
